// File: rtl/regfile_pkg.sv
// Shared sizing constants, loader state type and length check for the
// register-file bulk loader.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

    // A load must cover at least one word and never run past the last entry.
    function automatic logic lenLegal(input logic [ADDR_W:0] len);
        return (len != '0) && (len <= (ADDR_W+1)'(DEPTH));
    endfunction

endpackage

// File: rtl/regfile_mem.sv
// One-write/one-read register file with a registered read port that returns
// the old contents when the same entry is written in the same cycle.
module regfile_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] memArray_q [DEPTH];

    // Storage is deliberately left unreset so it maps onto plain RAM cells.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memArray_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= memArray_q[raddr_i];
        end
    end

endmodule

// File: rtl/regfile_loader.sv
// Bulk loader: after a legal start it streams len words into entries 0..len-1,
// keeps a running XOR checksum and pulses flag when the last word lands.
module regfile_loader
    import regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              busy_o,
    output logic              flag_o,
    output logic              err_o,
    output logic [DATA_W-1:0] checksum_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    ld_state_t         state_q, state_d;
    logic [ADDR_W:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_W:0]   lenReg_q, lenReg_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              err_q, err_d;
    logic              wrEn;

    assign wrEn = (state_q == LOAD) && in_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            lenReg_q   <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            lenReg_q   <= lenReg_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
        end
    end

    // wrPtr is one bit wider than the address so a full-depth load can count
    // its final word without wrapping.
    always_comb begin
        state_d    = state_q;
        wrPtr_d    = wrPtr_q;
        lenReg_d   = lenReg_q;
        checksum_d = checksum_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (lenLegal(len_i)) begin
                        lenReg_d   = len_i;
                        wrPtr_d    = '0;
                        checksum_d = '0;
                        state_d    = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_valid_i) begin
                    checksum_d = checksum_q ^ in_data_i;
                    wrPtr_d    = wrPtr_q + (ADDR_W+1)'(1);
                    if ((wrPtr_q + (ADDR_W+1)'(1)) == lenReg_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        flag_o     = 1'b0;
        err_o      = err_q;
        case (state_q)
            LOAD: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b1;
            end
            DONE: begin
                busy_o = 1'b1;
                flag_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign checksum_o = checksum_q;

    regfile_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wrEn),
        .waddr_i (wrPtr_q[ADDR_W-1:0]),
        .wdata_i (in_data_i),
        .raddr_i (rd_addr_i),
        .rdata_o (rd_data_o)
    );

endmodule

// File: tb/tb_regfile_loader.sv
// Scoreboard bench for regfile_loader: the driver pushes expected flag/err
// events and read data, and a negedge monitor retires them against the DUT.
module tb_regfile_loader;

    typedef struct {
        bit          isErr;
        logic [31:0] sum;
        int          cycle;
    } evExp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        startIn;
    logic [4:0]  lenIn;
    logic        inValid;
    logic [31:0] inData;
    logic        inReady;
    logic        busy;
    logic        flag;
    logic        err;
    logic [31:0] checksum;
    logic [3:0]  rdAddr;
    logic [31:0] rdData;

    evExp_t      evQ[$];
    logic [31:0] readQ[$];
    logic [31:0] refMem[16];
    bit          refKnown[16];
    logic [31:0] refChecksum;
    logic [31:0] ldWords[16];
    int          ldGap[16];

    int          cycleCnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        rdReq;
    logic        rdPending;
    logic        chkReady;
    logic        expReady;
    bit          collidePending;
    logic [31:0] collideVal;

    regfile_loader dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .start_i    (startIn),
        .len_i      (lenIn),
        .in_valid_i (inValid),
        .in_data_i  (inData),
        .in_ready_o (inReady),
        .busy_o     (busy),
        .flag_o     (flag),
        .err_o      (err),
        .checksum_o (checksum),
        .rd_addr_i  (rdAddr),
        .rd_data_o  (rdData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) rdPending <= 1'b0;
        else       rdPending <= rdReq;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Monitor: every comparison in the bench happens here.
    always @(negedge clk) begin : monitor
        evExp_t ev;
        if (!rstN) begin
            checkOutput("rstInReady", 32'(inReady), 32'd0);
            checkOutput("rstBusy", 32'(busy), 32'd0);
            checkOutput("rstFlag", 32'(flag), 32'd0);
            checkOutput("rstErr", 32'(err), 32'd0);
            checkOutput("rstChecksum", checksum, 32'd0);
            checkOutput("rstRdData", rdData, 32'd0);
        end else begin
            if (chkReady) checkOutput("inReady", 32'(inReady), 32'(expReady));
            if (rdPending) begin
                if (readQ.size() == 0) checkOutput("unexpectedRead", 32'd1, 32'd0);
                else checkOutput("rdData", rdData, readQ.pop_front());
            end
            if (flag || err) begin
                if (evQ.size() == 0) begin
                    checkOutput("unexpectedEvent", {30'd0, flag, err}, 32'd0);
                end else begin
                    ev = evQ.pop_front();
                    checkOutput("evIsFlag", 32'(flag), ev.isErr ? 32'd0 : 32'd1);
                    checkOutput("evIsErr", 32'(err), ev.isErr ? 32'd1 : 32'd0);
                    checkOutput("evCycle", 32'(cycleCnt), 32'(ev.cycle));
                    checkOutput("evChecksum", checksum, ev.sum);
                    checkOutput("evBusy", 32'(busy), ev.isErr ? 32'd0 : 32'd1);
                end
            end else if (evQ.size() > 0 && evQ[0].cycle < cycleCnt) begin
                ev = evQ.pop_front();
                checkOutput("missingEvent", 32'd0, 32'(ev.cycle));
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
        chkReady = 1'b0;
        if (collidePending) begin
            rdAddr = 4'd1;
            rdReq = 1'b1;
            readQ.push_back(collideVal);
            collidePending = 1'b0;
        end else begin
            rdReq = 1'b0;
        end
    endtask

    // Load ldWords[0..len-1]; ldGap[j] idle cycles precede word j.
    task automatic applyStimulus(input int len, input bit holdStart, input bit collide);
        evExp_t ev;
        int s;
        int stalls = 0;
        logic [31:0] sum = 32'd0;
        for (int j = 0; j < len; j++) begin
            sum = sum ^ ldWords[j];
            if (j > 0) stalls += ldGap[j];
        end
        s = cycleCnt;
        startIn = 1'b1;
        lenIn = 5'(len);
        inValid = 1'b0;
        chkReady = 1'b1;
        expReady = 1'b0;
        ev.isErr = 1'b0;
        ev.sum = sum;
        ev.cycle = s + len + stalls + 1;
        evQ.push_back(ev);
        refChecksum = sum;
        for (int j = 0; j < len; j++) begin
            if (j > 0) begin
                for (int g = 0; g < ldGap[j]; g++) begin
                    nextCycle();
                    startIn = holdStart;
                    lenIn = 5'd0;
                    inValid = 1'b0;
                    chkReady = 1'b1;
                    expReady = 1'b1;
                end
            end
            nextCycle();
            startIn = holdStart;
            lenIn = 5'd0;
            inValid = 1'b1;
            inData = ldWords[j];
            chkReady = 1'b1;
            expReady = 1'b1;
            if (collide && j == 1) begin
                rdAddr = 4'd1;
                rdReq = 1'b1;
                readQ.push_back(refMem[1]);
                collidePending = 1'b1;
                collideVal = ldWords[1];
            end
            refMem[j] = ldWords[j];
            refKnown[j] = 1'b1;
        end
        nextCycle();
        inValid = 1'b0;
        startIn = holdStart;
        lenIn = 5'd0;
        chkReady = 1'b1;
        expReady = 1'b0;
        nextCycle();
        startIn = 1'b0;
        chkReady = 1'b1;
        expReady = 1'b0;
    endtask

    task automatic errStart(input int len);
        evExp_t ev;
        startIn = 1'b1;
        lenIn = 5'(len);
        chkReady = 1'b1;
        expReady = 1'b0;
        ev.isErr = 1'b1;
        ev.sum = refChecksum;
        ev.cycle = cycleCnt + 1;
        evQ.push_back(ev);
        nextCycle();
        startIn = 1'b0;
        chkReady = 1'b1;
        expReady = 1'b0;
        nextCycle();
        chkReady = 1'b1;
        expReady = 1'b0;
    endtask

    task automatic readRange(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            rdAddr = 4'(a);
            rdReq = 1'b1;
            readQ.push_back(refMem[a]);
            nextCycle();
        end
    endtask

    // Five-word load aborted by reset after two words have been accepted.
    task automatic resetMidLoad();
        startIn = 1'b1;
        lenIn = 5'd5;
        nextCycle();
        startIn = 1'b0;
        lenIn = 5'd0;
        for (int j = 0; j < 2; j++) begin
            if (j > 0) nextCycle();
            inValid = 1'b1;
            inData = $urandom();
            refMem[j] = inData;
            refKnown[j] = 1'b1;
        end
        nextCycle();
        inValid = 1'b0;
        rstN = 1'b0;
        refChecksum = 32'd0;
        nextCycle();
        nextCycle();
        rstN = 1'b1;
        nextCycle();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int op;
        int len;
        bit hold;
        bit col;
        rstN = 1'b1;
        startIn = 1'b0;
        lenIn = 5'd0;
        inValid = 1'b0;
        inData = 32'd0;
        rdAddr = 4'd0;
        rdReq = 1'b0;
        chkReady = 1'b0;
        expReady = 1'b0;
        collidePending = 1'b0;
        collideVal = 32'd0;
        refChecksum = 32'd0;
        for (int j = 0; j < 16; j++) begin
            refMem[j] = 32'd0;
            refKnown[j] = 1'b0;
            ldGap[j] = 0;
            ldWords[j] = 32'd0;
        end
        #1 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        nextCycle();

        $display("[TB] nominal load");
        ldWords[0] = 32'h11111111;
        ldWords[1] = 32'h22222222;
        ldWords[2] = 32'h44444444;
        ldWords[3] = 32'h88888888;
        applyStimulus(4, 1'b0, 1'b0);
        readRange(0, 3);

        $display("[TB] stalled source");
        for (int j = 0; j < 3; j++) ldWords[j] = $urandom();
        ldGap[1] = 2;
        ldGap[2] = 2;
        applyStimulus(3, 1'b1, 1'b0);
        readRange(0, 2);
        for (int j = 0; j < 16; j++) ldGap[j] = 0;

        $display("[TB] illegal lengths");
        errStart(0);
        errStart(17);

        $display("[TB] full depth then back-to-back");
        for (int j = 0; j < 16; j++) ldWords[j] = 32'(j);
        applyStimulus(16, 1'b0, 1'b0);
        ldWords[0] = 32'hDEADBEEF;
        applyStimulus(1, 1'b0, 1'b0);
        readRange(0, 15);

        $display("[TB] reset mid-load");
        resetMidLoad();
        ldWords[0] = $urandom();
        applyStimulus(1, 1'b0, 1'b0);
        readRange(0, 1);

        $display("[TB] read/write collision");
        ldWords[0] = $urandom();
        ldWords[1] = 32'hA5A5A5A5;
        ldWords[2] = $urandom();
        applyStimulus(3, 1'b0, 1'b1);
        readRange(0, 2);

        $display("[TB] randomized loads");
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 9);
            if (op < 2) begin
                errStart(op == 0 ? 0 : int'($urandom_range(17, 31)));
            end else begin
                len = $urandom_range(1, 16);
                for (int j = 0; j < 16; j++) begin
                    ldWords[j] = $urandom();
                    ldGap[j] = $urandom_range(0, 2);
                end
                hold = 1'($urandom_range(0, 1));
                col = (len >= 2 && refKnown[1]) ? 1'($urandom_range(0, 1)) : 1'b0;
                applyStimulus(len, hold, col);
                for (int r = 0; r < 3; r++) begin
                    op = $urandom_range(0, len - 1);
                    readRange(op, op);
                end
            end
        end

        for (int w = 0; w < 40; w++) begin
            if (evQ.size() == 0 && readQ.size() == 0) break;
            nextCycle();
        end
        nextCycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
